// File: rtl/posedge_seq_pkg.sv
// posedge_seq_pkg: shared FSM state type and widths for the posedge count sequencer
package posedge_seq_pkg;
  localparam int COUNT_W = 32;
  localparam int MAX_SIG = 8;
  typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;
endpackage

// File: rtl/edge_sync_detect.sv
// edge_sync_detect: 2-flop synchronizer plus rising-edge detector for one channel
// ports: clk, rst (sync, active-high), sig (asynchronous input), rise (high for one cycle per synced 0->1)
module edge_sync_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);
  logic s1, s2, prev;
  logic [1:0] fill;
  // fill holds rise off until prev carries a real synced sample, so a level already high at reset release is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      fill <= 2'd0;
    end else begin
      s1 <= sig;
      s2 <= s1;
      prev <= s2;
      fill <= fill + {1'b0, fill != 2'd3};
    end
  end
  assign rise = s2 & ~prev & (fill == 2'd3);
endmodule

// File: rtl/posedge_count_sequencer.sv
// posedge_count_sequencer: windowed per-channel rising-edge counter sequenced through IDLE/COUNT/LATCH
// ports: axi_clk, axi_reset (sync, active-high), input_signals (async channels), start/abort/continuous controls,
//        window_len (cycles per window), busy, done (publication pulse), result (per-channel counts),
//        window_count (published windows); overflow (per-channel saturation) exists only with POSEDGE_SEQ_SATURATE_EN
module posedge_count_sequencer
  import posedge_seq_pkg::*;
#(
  parameter int NUM_SIG = 8
) (
  input  logic                              axi_clk,
  input  logic                              axi_reset,
  input  logic [NUM_SIG-1:0]                input_signals,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              continuous,
  input  logic [COUNT_W-1:0]                window_len,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_SIG-1:0][COUNT_W-1:0]   result,
  output logic [COUNT_W-1:0]                window_count
`ifdef POSEDGE_SEQ_SATURATE_EN
  ,
  output logic [NUM_SIG-1:0]                overflow
`endif
);
  state_t state;
  logic [COUNT_W-1:0] timer;
  logic [NUM_SIG-1:0][COUNT_W-1:0] cnt, cnt_inc;
  logic [NUM_SIG-1:0] rise;
  logic launch, step, publish;
`ifdef POSEDGE_SEQ_SATURATE_EN
  logic [NUM_SIG-1:0] sat, hit;
`endif
  assign launch = state == IDLE && start && !abort && window_len != '0;
  assign step = state == COUNT && !abort;
  assign publish = state == LATCH && !abort;
  for (genvar i = 0; i < NUM_SIG; i++) begin : g_ch
    edge_sync_detect u_sync (
      .clk(axi_clk),
      .rst(axi_reset),
      .sig(input_signals[i]),
      .rise(rise[i])
    );
`ifdef POSEDGE_SEQ_SATURATE_EN
    assign hit[i] = rise[i] & (&cnt[i]);
    assign cnt_inc[i] = cnt[i] + COUNT_W'(rise[i] & ~hit[i]);
`else
    assign cnt_inc[i] = cnt[i] + COUNT_W'(rise[i]);
`endif
  end
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state <= IDLE;
      timer <= '0;
      cnt <= '0;
      result <= '0;
      window_count <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (launch) begin
          state <= COUNT;
          busy <= 1'b1;
          timer <= window_len;
          cnt <= '0;
        end
        COUNT: if (step) begin
          timer <= timer - 32'd1;
          cnt <= cnt_inc;
          if (timer == 32'd1) state <= LATCH;
        end else begin
          state <= IDLE;
          busy <= 1'b0;
        end
        LATCH: if (publish) begin
          result <= cnt;
          window_count <= window_count + 32'd1;
          done <= 1'b1;
          if (continuous) begin
            state <= COUNT;
            timer <= window_len;
            // the LATCH-cycle edge opens the next window so it is never lost
            for (int k = 0; k < NUM_SIG; k++) cnt[k] <= COUNT_W'(rise[k]);
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end else begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
`ifdef POSEDGE_SEQ_SATURATE_EN
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      sat <= '0;
      overflow <= '0;
    end else begin
      if (launch || (publish && continuous)) sat <= '0;
      else if (step) sat <= sat | hit;
      if (publish) overflow <= sat;
    end
  end
`endif
endmodule

// File: doc/posedge_count_sequencer.md
POSEDGE_COUNT_SEQUENCER -- requirements
Module: posedge_count_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_SIG, default 8, giving the number of counted channels (legal range 1..8).
REQ-002 The block SHALL have port axi_clk, input, 1 bit: the single clock for all logic.
REQ-003 The block SHALL have port axi_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port input_signals, input, NUM_SIG bits: asynchronous signals whose rising edges are counted.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin a measurement.
REQ-006 The block SHALL have port abort, input, 1 bit: terminates a measurement without publishing results.
REQ-007 The block SHALL have port continuous, input, 1 bit: when high, windows repeat back-to-back.
REQ-008 The block SHALL have port window_len, input, 32 bits: window length in axi_clk cycles.
REQ-009 The block SHALL have port busy, output, 1 bit: high in COUNT and LATCH.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a window's results are published.
REQ-011 The block SHALL have port result, output, NUM_SIG x 32 bits: published per-channel edge counts.
REQ-012 The block SHALL have port window_count, output, 32 bits: number of completed windows.

Function
REQ-013 Each channel SHALL pass through a 2-flop synchronizer followed by a rising-edge detector (previous 0, current 1), giving 3 cycles of latency from the input edge to the counter increment.
REQ-014 The FSM SHALL have the states IDLE, COUNT and LATCH.
REQ-015 In IDLE, start with window_len != 0 SHALL move the FSM to COUNT, clear all live counters, and load timer = window_len.
REQ-016 In IDLE, start with window_len == 0 SHALL be ignored: the FSM stays in IDLE and done is not pulsed.
REQ-017 A start received in COUNT or LATCH SHALL be ignored.
REQ-018 window_len SHALL be sampled only at start and at a continuous reload, so changes made mid-window have no effect.
REQ-019 In COUNT, the timer SHALL decrement every cycle, and each detected edge SHALL increment its live counter.
REQ-020 When timer == 1 in COUNT, the FSM SHALL enter LATCH on the next cycle, and edges detected in that final COUNT cycle SHALL be included in the window.
REQ-021 In LATCH: result SHALL be set to the live counters; done SHALL be 1 for exactly this cycle; window_count SHALL increment, wrapping modulo 2^32.
REQ-022 From LATCH with continuous=1, the FSM SHALL return to COUNT with the timer reloaded, and each live counter SHALL be loaded with that channel's LATCH-cycle edge bit (0 or 1), so no edge is lost.
REQ-023 From LATCH with continuous=0, the FSM SHALL go to IDLE, and LATCH-cycle edges SHALL be discarded.
REQ-024 abort in COUNT or LATCH SHALL move the FSM to IDLE next cycle, with result and window_count unchanged and no done pulse; in LATCH, abort SHALL suppress that cycle's publication.
REQ-025 abort SHALL take priority over start; abort in IDLE SHALL have no effect.
REQ-026 result SHALL hold its value until the next publication.
REQ-027 Live counters are 32 bits and SHALL wrap modulo 2^32 (see REQ-031 for the exception).

Reset
REQ-028 While axi_reset is high at a rising edge of axi_clk, the block SHALL clear FSM=IDLE, timer=0, live counters=0, result=0, window_count=0, done=0, busy=0, and all synchronizer and edge-detector flops to 0.
REQ-029 A reset asserted mid-window SHALL discard that window with no done pulse.
REQ-030 A channel held high through reset release SHALL NOT produce a counted edge.

Configuration
REQ-031 With POSEDGE_SEQ_SATURATE_EN defined: live counters SHALL saturate at 0xFFFFFFFF, and an extra output overflow (NUM_SIG bits) SHALL carry the per-channel saturation flag, published and reset like result.
REQ-032 Without POSEDGE_SEQ_SATURATE_EN, counters SHALL wrap per REQ-027 and the overflow port SHALL NOT exist.

Structure
REQ-033 Package posedge_seq_pkg SHALL hold the FSM state enum, COUNT_W=32, and MAX_SIG=8.
REQ-034 The synchronizer and edge detector SHALL be one sub-module, edge_sync_detect, instantiated per channel.

Verification
REQ-035 Reset; window_len=10; start; drive 4 edges on ch0 well inside the window: done pulses 12 cycles after start (1 transition + 10 COUNT + LATCH), result[0]=4, result[1..7]=0, window_count=1.
REQ-036 window_len=0; start: busy stays 0, no done, result unchanged.
REQ-037 continuous=1, window_len=5, ch2 toggled every 2 cycles for 30 cycles: done every 6 cycles, and the sum of the result[2] values over the windows equals the total detected edges.
REQ-038 window_len=100; start; abort at cycle 50: busy drops the next cycle, no done, result and window_count unchanged.
REQ-039 Edge timed to be detected in the last COUNT cycle: counted in that window; edge detected in the LATCH cycle with continuous=1: appears as 1 in the next window.
REQ-040 Live counter preloaded to 0xFFFFFFFF via force, then 1 edge: result=0 without the macro; result=0xFFFFFFFF and overflow=1 with POSEDGE_SEQ_SATURATE_EN.
